// File: rtl/expr_eval.sv
// expr_eval: streaming evaluator for single-digit '+'/'*' expressions
// terminated by '='. '*' binds tighter than '+'. All arithmetic wraps
// modulo 2^W. A malformed expression (anything other than strict
// digit/operator alternation that starts and ends with a digit) produces an
// err pulse together with done, and result keeps its previous value.
//
// Ports:
//   clk       system clock, rising edge
//   clr       asynchronous active-high reset
//   in        ASCII character ('0'..'9', '*', '+', '=')
//   in_valid  character strobe; in is consumed only when high
//   result    value of the last well-formed expression
//   done      one-cycle pulse after an '=' is consumed
//   err       one-cycle pulse with done when the expression was malformed
//   active    high while the current expression has consumed characters
module expr_eval #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [7:0]   in,
  input  logic         in_valid,
  output logic [W-1:0] result,
  output logic         done,
  output logic         err,
  output logic         active
);

  typedef enum logic [1:0] {
    EXP_NUM = 2'b00,
    EXP_OP  = 2'b01,
    ERROR   = 2'b11
  } state_t;

  localparam logic [7:0] CH_MUL  = 8'd42;
  localparam logic [7:0] CH_ADD  = 8'd43;
  localparam logic [7:0] CH_EQ   = 8'd61;
  localparam logic [7:0] CH_ZERO = 8'd48;
  localparam logic [7:0] CH_NINE = 8'd57;

  state_t       state_q, state_d;
  logic [W-1:0] sum_q, sum_d;
  logic [W-1:0] term_q, term_d;
  logic         mul_pend_q, mul_pend_d;
  logic [W-1:0] result_d;
  logic         done_d, err_d, active_d;

  // Character classification.
  logic         is_digit, is_eq;
  logic [7:0]   digit_off;
  logic [W-1:0] digit_w;

  assign is_digit  = (in >= CH_ZERO) && (in <= CH_NINE);
  assign is_eq     = (in == CH_EQ);
  assign digit_off = in - CH_ZERO;
  assign digit_w   = W'(digit_off[3:0]);

  // NOTE: every next-value signal is given a default before the case logic,
  // so each path assigns it and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    term_d     = term_q;
    mul_pend_d = mul_pend_q;
    result_d   = result;
    done_d     = 1'b0;
    err_d      = 1'b0;
    active_d   = active;

    if (in_valid) begin
      if (is_eq) begin
        // '=' always closes the expression; only a clean EXP_OP end succeeds.
        done_d     = 1'b1;
        active_d   = 1'b0;
        sum_d      = '0;
        term_d     = '0;
        mul_pend_d = 1'b0;
        state_d    = EXP_NUM;
        if (state_q == EXP_OP) begin
          result_d = sum_q + term_q;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        active_d = 1'b1;
        case (state_q)
          EXP_NUM: begin
            if (is_digit) begin
              // A pending '*' folds the digit into the running product term.
              term_d  = mul_pend_q ? (term_q * digit_w) : digit_w;
              state_d = EXP_OP;
            end else begin
              state_d = ERROR;
            end
          end
          EXP_OP: begin
            if (in == CH_ADD) begin
              sum_d      = sum_q + term_q;
              mul_pend_d = 1'b0;
              state_d    = EXP_NUM;
            end else if (in == CH_MUL) begin
              mul_pend_d = 1'b1;
              state_d    = EXP_NUM;
            end else begin
              // Second consecutive digit or an unknown character.
              state_d = ERROR;
            end
          end
          ERROR: begin
            // Swallow everything until '='.
          end
          default: begin
            state_d = ERROR;
          end
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= EXP_NUM;
      sum_q      <= '0;
      term_q     <= '0;
      mul_pend_q <= 1'b0;
      result     <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      active     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      term_q     <= term_d;
      mul_pend_q <= mul_pend_d;
      result     <= result_d;
      done       <= done_d;
      err        <= err_d;
      active     <= active_d;
    end
  end

endmodule

// File: doc/expr_eval.md
# expr_eval

Downstream consumer of the character stream that the digit/operator recognizer checks. Evaluates single-digit integer expressions using `+` and `*` with normal precedence (`*` binds tighter), terminated by `=`, and presents a registered result with a one-cycle completion pulse. It runs the same digit/operator alternation check internally and flags malformed expressions instead of producing a value.

## Interface
- W, 16, width of result and all internal accumulators; arithmetic is modulo 2^W
- clk  input  1  system clock, all state changes on rising edge
- clr  input  1  reset, asynchronous, active-high
- in  input  8  ASCII character: '0'..'9' (48..57), '*' (42), '+' (43), '=' (61)
- in_valid  input  1  character strobe; `in` is consumed on a rising edge only when 1
- result  output  W  value of last well-formed expression; holds until next success
- done  output  1  one-cycle pulse: an `=` was consumed
- err  output  1  one-cycle pulse coincident with `done`: the terminated expression was malformed
- active  output  1  high while at least one character of the current expression has been consumed

## Operation
- State register, 2 bits: EXP_NUM (2'b00), EXP_OP (2'b01), ERROR (2'b11). Internal regs: `sum` [W], `term` [W], `mul_pend` [1].
- Character classes: DIGIT = 48..57 (value d = in-48), OP = 42 or 43, EQ = 61, OTHER = everything else.
- EXP_NUM:
  - DIGIT: term <= mul_pend ? term*d : d (truncated to W); -> EXP_OP.
  - EQ: done=1, err=1, result unchanged; clear sum/term/mul_pend; -> EXP_NUM.
  - OP or OTHER: -> ERROR.
- EXP_OP:
  - '+': sum <= sum+term; mul_pend <= 0; -> EXP_NUM.
  - '*': mul_pend <= 1; -> EXP_NUM.
  - EQ: result <= sum+term (mod 2^W); done=1, err=0; clear sum/term/mul_pend; -> EXP_NUM.
  - DIGIT or OTHER: -> ERROR (multi-digit numbers are illegal).
- ERROR: every non-EQ character is ignored; EQ gives done=1, err=1, result unchanged, clears internals, -> EXP_NUM.
- in_valid=0: no state or register change; done and err are 0 that cycle.
- active: set on any consumed non-EQ character; cleared on consumed EQ and on reset.
- No limit on expression length; accumulators wrap silently.

## Timing
- Reset (clr=1, asynchronous, takes effect immediately, no clock needed): state=EXP_NUM, sum=0, term=0, mul_pend=0, result=0, done=0, err=0, active=0. Held reset ignores in/in_valid.
- Reset mid-expression discards partial work; no done/err pulse produced for the aborted expression.
- All outputs registered. The EQ character sampled at edge N yields result/done/err valid after edge N, for exactly one cycle (cleared at edge N+1 unless another EQ is consumed at N+1).
- Back-to-back expressions with in_valid held high are supported: first character of the next expression may be consumed on the edge immediately after the EQ.
- Throughput: one character per cycle; latency from final EQ to result: 1 cycle.

## Test plan
- Reset then stream "3+4*5=" with in_valid=1 every cycle -> done pulses once, err=0, result=23, active low after pulse.
- "2*3*4=" then immediately "7=" -> first done with result=24, next done with result=7, two pulses separated by exactly two cycles.
- "1+=" -> done=1, err=1, result keeps prior value (0 after reset); then "8=" -> result=8, err=0.
- "12+3=", "=" alone, and "5a=" -> each gives done=1, err=1, result unchanged; characters after the fault ignored until '='.
- W=8, "9*9*9*9=" -> result=161 (6561 mod 256); "9*9*9*9+99" style not used; also "9+9+...(30 nines)=" -> 270 mod 256 = 14.
- "4+" then in_valid=0 for 5 cycles then "6=" -> result=10, no outputs change during gap; separately assert clr asynchronously between "4+" and "6=" -> "6=" yields result=6, no pulse at reset.
